// File: rtl/eff_sel_ctrl.sv
// Click-free effect switching: debounce sw_i, fade out, swap sel_o, flush, fade in.
// Latency: data_o/vld_o one cycle after data_i/vld_i; no backpressure, every sample is passed on.
module eff_sel_ctrl #(
   parameter int               SEL_W         = 16,
   parameter int               DATA_W        = 24,
   parameter int               GAIN_W        = 6,
   parameter int               DEB_CYCLES    = 65536,
   parameter int               FLUSH_SAMPLES = 8,
   parameter logic [SEL_W-1:0] RESET_SEL     = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SEL_W-1:0]  sw_i,
   output logic [SEL_W-1:0]  sel_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              vld_i,
   output logic [DATA_W-1:0] data_o,
   output logic              vld_o,
   output logic              busy_o
);

   localparam int DEB_W = $clog2(DEB_CYCLES);
   localparam int FL_W  = $clog2(FLUSH_SAMPLES + 1);
   localparam int PW    = DATA_W + GAIN_W + 2;

   localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEB_CYCLES - 1);
   localparam logic [FL_W-1:0]   FL_LAST = FL_W'(FLUSH_SAMPLES - 1);
   localparam logic [GAIN_W:0]   UNITY   = {1'b1, {GAIN_W{1'b0}}};
   localparam logic [GAIN_W:0]   G_ONE   = (GAIN_W+1)'(1);

   typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

   logic [SEL_W-1:0]  sw_m, sw_s, cand, pend;
   logic [DEB_W-1:0]  deb_cnt;
   logic              chg;

   state_t            state, state_nx;
   logic [GAIN_W:0]   gain, gain_nx;
   logic [FL_W-1:0]   flush_cnt, flush_nx, flush_base;
   logic              swap_ld, ld_nx;
   logic signed [PW-1:0] prod;

   // Debounce: a value must sit unchanged on sw_s for DEB_CYCLES before it is accepted.
   assign chg = (sw_s == cand) && (deb_cnt == DEB_MAX) && (cand != pend);

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_m    <= RESET_SEL;
         sw_s    <= RESET_SEL;
         cand    <= RESET_SEL;
         pend    <= RESET_SEL;
         deb_cnt <= '0;
      end else begin
         sw_m <= sw_i;
         sw_s <= sw_m;
         if (sw_s != cand) begin
            cand    <= sw_s;
            deb_cnt <= '0;
         end else if (deb_cnt != DEB_MAX) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
         if (chg) pend <= cand;
      end
   end

   // swap_ld delays the sel_o load by one clock so it always sees the updated pend.
   assign flush_base = swap_ld ? '0 : flush_cnt;

   always_comb begin
      state_nx = state;
      gain_nx  = gain;
      flush_nx = flush_cnt;
      ld_nx    = 1'b0;
      case (state)
         IDLE: begin
            gain_nx = UNITY;
            if (chg) state_nx = FADE_OUT;
         end
         FADE_OUT: begin
            if (gain == '0) begin
               state_nx = SWAP;
               ld_nx    = 1'b1;
               flush_nx = '0;
            end else if (vld_i) begin
               gain_nx = gain - G_ONE;
               if (gain == G_ONE) begin
                  state_nx = SWAP;
                  ld_nx    = 1'b1;
                  flush_nx = '0;
               end
            end
         end
         SWAP: begin
            gain_nx  = '0;
            flush_nx = flush_base;
            if (chg) begin
               ld_nx    = 1'b1;
               flush_nx = '0;
            end else if (vld_i) begin
               if (flush_base == FL_LAST) state_nx = FADE_IN;
               else                       flush_nx = flush_base + FL_W'(1);
            end
         end
         FADE_IN: begin
            if (vld_i) begin
               gain_nx = gain + G_ONE;
               if (gain + G_ONE == UNITY) state_nx = IDLE;
            end
            if (chg) state_nx = FADE_OUT;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign prod   = $signed(data_i) * $signed({1'b0, gain});
   assign busy_o = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gain      <= UNITY;
         flush_cnt <= '0;
         swap_ld   <= 1'b0;
         sel_o     <= RESET_SEL;
         data_o    <= '0;
         vld_o     <= 1'b0;
      end else begin
         state     <= state_nx;
         gain      <= gain_nx;
         flush_cnt <= flush_nx;
         swap_ld   <= ld_nx;
         if (swap_ld) sel_o <= pend;
         vld_o <= vld_i;
         if (vld_i) begin
            if (state == SWAP) data_o <= '0;
            else               data_o <= DATA_W'(prod >>> GAIN_W);
         end
      end
   end

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Random-data bench for eff_sel_ctrl: a sample-level fade model feeds a scoreboard that a monitor drains.
module tb_eff_sel_ctrl;

   localparam int DEB   = 16;
   localparam int FLUSH = 8;
   localparam int UNITY = 64;
   localparam int P_IDLE = 0, P_FO = 1, P_SW = 2, P_FI = 3;

   logic        clk, rst;
   logic [15:0] sw_i, sel_o;
   logic [23:0] data_i, data_o;
   logic        vld_i, vld_o, busy_o;

   eff_sel_ctrl #(
      .SEL_W(16), .DATA_W(24), .GAIN_W(6), .DEB_CYCLES(DEB),
      .FLUSH_SAMPLES(FLUSH), .RESET_SEL(16'hFFFF)
   ) dut (
      .clk(clk), .rst(rst), .sw_i(sw_i), .sel_o(sel_o),
      .data_i(data_i), .vld_i(vld_i), .data_o(data_o),
      .vld_o(vld_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int          exp_d[$];
   logic [15:0] exp_s[$];
   bit          exp_b[$];

   int          m_phase, m_g, m_fl;
   logic [15:0] m_sel, m_pend;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE;
      m_g     = UNITY;
      m_fl    = 0;
      m_sel   = 16'hFFFF;
      m_pend  = 16'hFFFF;
   endtask

   // Expected output of one sample, then advance the fade sequence by that sample.
   task automatic model_sample(input logic [23:0] d);
      longint p, q;
      p = longint'($signed(d)) * m_g;
      q = p / UNITY;
      if (p % UNITY != 0 && p < 0) q = q - 1;
      if (m_phase == P_SW) q = 0;
      exp_d.push_back(int'(q));
      exp_s.push_back(m_sel);
      case (m_phase)
         P_FO: begin
            m_g--;
            if (m_g == 0) begin
               m_phase = P_SW;
               m_fl    = 0;
               m_sel   = m_pend;
            end
         end
         P_SW: begin
            m_fl++;
            if (m_fl == FLUSH) m_phase = P_FI;
         end
         P_FI: begin
            m_g++;
            if (m_g == UNITY) m_phase = P_IDLE;
         end
         default: ;
      endcase
      exp_b.push_back(m_phase != P_IDLE);
   endtask

   task automatic model_switch(input logic [15:0] v);
      if (v != m_pend) begin
         m_pend = v;
         case (m_phase)
            P_IDLE: m_phase = P_FO;
            P_SW: begin
               m_sel = v;
               m_fl  = 0;
            end
            P_FI: m_phase = P_FO;
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] d);
      data_i = d;
      vld_i  = 1'b1;
      model_sample(d);
      tick();
      vld_i = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic send_rand();
      logic [23:0] r;
      r = 24'($urandom);
      send(r);
   endtask

   // Switch change applied while no samples flow, so it lands between two known samples.
   task automatic accept(input logic [15:0] v);
      sw_i = v;
      repeat (DEB + 8) tick();
      model_switch(v);
   endtask

   task automatic run_to_idle(input bit rnd, input logic [23:0] d);
      int n;
      n = 0;
      while (m_phase != P_IDLE && n < 400) begin
         if (rnd) send_rand();
         else     send(d);
         n++;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && vld_o === 1'b1) begin
         if (exp_d.size() == 0) begin
            chk("unexpected_vld_o", 1, 0);
         end else begin
            chk("data_o", longint'($signed(data_o)), longint'(exp_d.pop_front()));
            chk("sel_o", longint'(sel_o), longint'(exp_s.pop_front()));
            chk("busy_o", longint'(busy_o), longint'(exp_b.pop_front()));
         end
      end
   end

   initial begin
      int bounce_busy;
      int w;
      rst    = 1'b1;
      sw_i   = 16'hFFFF;
      data_i = 24'h00AAAA;
      vld_i  = 1'b1;
      model_reset();
      repeat (2) tick();
      chk("rst_sel", longint'(sel_o), 64'hFFFF);
      chk("rst_vld", longint'(vld_o), 0);
      chk("rst_data", longint'(data_o), 0);
      chk("rst_busy", longint'(busy_o), 0);
      rst   = 1'b0;
      vld_i = 1'b0;
      tick();

      data_i = 24'h123456;
      vld_i  = 1'b1;
      model_sample(24'h123456);
      tick();
      vld_i = 1'b0;
      chk("first_vld", longint'(vld_o), 1);
      chk("first_data", longint'(data_o), 64'h123456);
      tick();

      accept(16'h0003);
      chk("chg_busy", longint'(busy_o), 1);
      repeat (UNITY + FLUSH + UNITY + 2) send(24'd640000);
      chk("clean_sel", longint'(sel_o), 64'h0003);
      chk("clean_busy", longint'(busy_o), 0);

      bounce_busy = 0;
      for (int t = 0; t < 10; t++) begin
         sw_i[0] = ~sw_i[0];
         repeat (DEB / 2) begin
            tick();
            if (busy_o) bounce_busy++;
         end
      end
      repeat (DEB + 8) begin
         tick();
         if (busy_o) bounce_busy++;
      end
      chk("bounce_busy_cycles", longint'(bounce_busy), 0);
      chk("bounce_sel", longint'(sel_o), 64'h0003);

      accept(16'h00F0);
      repeat (UNITY + FLUSH + 20) send_rand();
      accept(16'h0F00);
      run_to_idle(1'b1, 24'h0);
      chk("reverse_sel", longint'(sel_o), 64'h0F00);

      accept(16'h1234);
      run_to_idle(1'b0, 24'hFFFFFF);

      accept(16'h5555);
      repeat (UNITY + 3) send_rand();
      accept(16'hAAAA);
      run_to_idle(1'b1, 24'h0);
      chk("reswap_sel", longint'(sel_o), 64'hAAAA);

      accept(16'h0003);
      repeat (UNITY + 4) send_rand();
      repeat (4) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      model_reset();
      chk("midswap_rst_sel", longint'(sel_o), 64'hFFFF);
      chk("midswap_rst_busy", longint'(busy_o), 0);
      send(24'h7ABCDE);
      repeat (DEB + 8) tick();
      model_switch(16'h0003);
      run_to_idle(1'b1, 24'h0);
      chk("after_rst_sel", longint'(sel_o), 64'h0003);

      w = 0;
      while (exp_d.size() != 0 && w < 50) begin
         tick();
         w++;
      end
      chk("outstanding_samples", longint'(exp_d.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eff_sel_ctrl.md
# eff_sel_ctrl

Sequences effect-selection changes for the effects pipe so switching effects never produces clicks. Sits between the raw switch bank and `eff_pipe.sel`, and between the `eff_pipe` output and the I2S transmit input, all in the `mclk` domain. On a debounced switch change it:
- fades the output to silence,
- updates the selection,
- flushes stale samples,
- fades back in.

## Interface
Parameters:
- `SEL_W`, 16, width of switch/selection vector
- `DATA_W`, 24, signed sample width
- `GAIN_W`, 6, fade resolution; unity gain = 2^GAIN_W, fade length = 2^GAIN_W samples
- `DEB_CYCLES`, 65536, clocks a switch value must be stable to be accepted (≥2)
- `FLUSH_SAMPLES`, 8, muted samples after a selection swap (≥1)
- `RESET_SEL`, all ones, `sel_o` value after reset

Ports:
- `clk` in 1: mclk domain clock
- `rst` in 1: synchronous, active-high reset
- `sw_i` in SEL_W: raw asynchronous switch inputs
- `sel_o` out SEL_W: effect selection to `eff_pipe`
- `data_i` in DATA_W: signed sample from `eff_pipe`
- `vld_i` in 1: single-cycle sample strobe
- `data_o` out DATA_W: gain-scaled sample to I2S
- `vld_o` out 1: output strobe
- `busy_o` out 1: high whenever the state is not IDLE

## Operation
- **Switch synchroniser:** a 2-FF synchroniser on `sw_i`, giving `sw_s`.
- **Debounce:**
  - Candidate register `cand` and counter `deb_cnt`.
  - If `sw_s != cand`: `cand <= sw_s`, `deb_cnt <= 0`.
  - Otherwise, when `deb_cnt` reaches `DEB_CYCLES-1`, `cand` becomes stable.
  - `chg` pulses one cycle when a stable `cand != pend`; `pend <= cand` on that cycle.
  - `pend` resets to `RESET_SEL`.
- **Gain:** register `gain` is GAIN_W+1 bits wide, range 0..2^GAIN_W.
- **FSM states:**
  - **IDLE:** `gain` = 2^GAIN_W. On `chg`, go to FADE_OUT.
  - **FADE_OUT:**
    - On each `vld_i`, `gain` decrements by 1.
    - When a `vld_i` arrives with `gain == 1` (so `gain` becomes 0), go to SWAP.
    - `chg` here only updates `pend`; the state is unaffected.
  - **SWAP:**
    - On entry, `sel_o <= pend` and the flush counter is set to 0.
    - Each `vld_i` emits a zero sample and increments the counter.
    - After `FLUSH_SAMPLES` samples, go to FADE_IN.
    - If `chg` arrives during SWAP, `sel_o <= pend` again and the flush counter is reset to 0.
  - **FADE_IN:**
    - On each `vld_i`, `gain` increments.
    - When `gain` reaches 2^GAIN_W, go to IDLE.
    - On `chg`, go to FADE_OUT, continuing from the current `gain` (no jump).
- **Scaling:**
  - `data_o = (data_i * gain) >>> GAIN_W`, computed as a signed product with a zero-extended `gain`; the result is truncated toward −∞ by the arithmetic shift.
  - At unity, `data_o == data_i` exactly. At `gain` 0, `data_o = 0`.
  - No saturation is needed (|gain| ≤ unity).
- **Gain sampling:** the scaling uses the `gain` value before that cycle's `vld_i` update.
- **Sample flow:** samples are never dropped or inserted. `vld_o` count equals `vld_i` count in every state.

## Timing
- **Output latency:** `data_o`/`vld_o` are registered one cycle after `data_i`/`vld_i`. `vld_o` is high for exactly one cycle.
- **Selection update:** `sel_o` changes on the clock after the FADE_OUT→SWAP transition. It is constant outside SWAP entry and SWAP re-entry on `chg`.
- **Reset values:**
  - State IDLE, `gain` = 2^GAIN_W.
  - `sel_o` = `RESET_SEL`, `pend` = `cand` = `RESET_SEL`, `deb_cnt` = 0.
  - `data_o` = 0, `vld_o` = 0, `busy_o` = 0.
  - The synchroniser flops reset to `RESET_SEL`.
- **Reset mid-fade:** reset in any state applies the reset values on the next edge. No pending change survives.
- **Full sequence length:** an uninterrupted change from IDLE takes 2^GAIN_W + FLUSH_SAMPLES + 2^GAIN_W samples.
- **Simultaneous events:**
  - `chg` and the last fade-out `vld_i` on the same cycle: the transition to SWAP happens, and the swap uses the new `pend`.
  - `chg` on the last FADE_IN sample: FADE_OUT wins over IDLE.
- **Bounce:** toggles shorter than `DEB_CYCLES` never produce `chg`.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `vld_i` active.
  - Required: `sel_o` = 16'hFFFF, `vld_o` = 0, `data_o` = 0, `busy_o` = 0.
  - After release, `data_i` = 24'h123456 with `vld_i` gives `data_o` = 24'h123456 one cycle later.
- **Clean change** (`sw_i` 16'hFFFF→16'h0003, held > `DEB_CYCLES`, constant `data_i` = 24'sd640000, one `vld_i` every 256 clk):
  - Output ramps down by 10000 per sample: 640000, 630000, …, 10000.
  - Then 8 zero samples.
  - `sel_o` = 16'h0003 from the start of the zeros.
  - Then 0, 10000, …, back to 640000; `busy_o` falls.
- **Bounce:**
  - Stimulus: toggle `sw_i` bit 0 every `DEB_CYCLES`/2 clocks for 10 toggles, then hold it at its original value.
  - Required: no `chg`, `busy_o` stays 0, `sel_o` unchanged.
- **Reversal during FADE_IN:**
  - Stimulus: a second stable change arrives when `gain` = 20.
  - Required: the next samples use `gain` 20, 19, …, 0 (no jump), then the swap to the new value.
- **Negative rounding:**
  - Stimulus: `data_i` = −1, `gain` = 32.
  - Required: `data_o` = −1 (arithmetic shift); at unity `data_o` = −1.
- **Reset mid-SWAP:**
  - Stimulus: assert `rst` during the flush.
  - Required: `sel_o` returns to 16'hFFFF, unity gain immediately.
  - If the synchronised `sw_i` still differs from `RESET_SEL`, a new debounced change starts a full sequence.
